filter_ch_scheduler: RTL
========================

Name: filter_ch_scheduler

Overview:
- Time-multiplexes one 2-tap averaging datapath, y(n) = 0.5*(x(n) + x(n-1)), across N_CH independent sample channels.
- Each channel has its own x(n-1) history register and first-sample flag.
- A round-robin arbiter grants one requester per cycle.
- Sits between the per-channel sample sources and the downstream consumer; the output carries a channel tag.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- DW, 19, signed sample width of input and output.
- CW, 2, channel-id width; must satisfy 2**CW >= N_CH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N_CH  per-channel sample-valid.
- in_data  input  N_CH*DW  per-channel signed sample; channel k occupies bits [k*DW +: DW].
- in_ready  output  N_CH  per-channel accept; one-hot or zero.
- out_valid  output  1  result valid.
- out_data  output  DW  signed filtered result.
- out_ch  output  CW  channel id of out_data.
- out_ready  input  1  downstream accept.
- flush  input  1  one-cycle pulse: clear all channel histories.
- busy  output  1  high while the FSM is not in RUN, or out_valid is high.

Behaviour:
- Reset (async on rst_n low): out_valid=0, out_data=0, out_ch=0, in_ready=0, busy=0.
  - All history registers cleared to 0 and all first-sample flags set.
  - Round-robin pointer = 0; FSM = RUN.
- Handshakes: a transfer occurs on a cycle where valid and ready are both high at the rising edge. out_data and out_ch hold stable while out_valid=1 and out_ready=0.
- in_ready is combinational from FSM state, output-slot state, in_valid and the pointer.
  - The slot is free when out_valid=0, or out_valid=1 and out_ready=1.
  - At most one bit of in_ready is set, and only on a channel with in_valid=1.
- Arbitration: search from the pointer upward, modulo N_CH. The first channel with in_valid set is granted. After a grant to channel k, the pointer becomes (k+1) mod N_CH; with no grant it is unchanged.
- Datapath, for accepted channel k with sample x:
  - First sample for k: y = x >>> 1.
  - Otherwise: sum = sign-extended DW+1-bit x + hist[k]; y = sum >>> 1, truncated to DW bits. No overflow is possible.
  - hist[k] <= x; first-sample flag for k is cleared.
- Latency: one cycle. out_valid rises on the edge that accepts the input, and out_ch = k.
- Throughput: one sample per cycle when out_ready is held high.
- FSM states:
  - RUN: grants are allowed. When flush=1 and the output slot is free, go to FLUSH. When flush=1 and the slot is not free, go to DRAIN.
  - DRAIN: no grants. Wait for the out_valid/out_ready transfer, then go to FLUSH.
  - FLUSH: one cycle, no grants. Clear all histories to 0 and set all first-sample flags. Return to RUN.
- Simultaneous flush and in_valid in RUN: flush wins; in_ready=0 that cycle.
- flush asserted while in DRAIN or FLUSH is ignored (no re-trigger).
- Output slot in the same cycle as a new grant: drain and refill happen together; out_valid stays high.
- rst_n low mid-transfer: the pending output is discarded. No partial state survives.

Optional Feature:
- Macro: FILTER_ROUND_EN.
- Defined: the non-first sample result is y = (sum + 1) >>> 1 (round half toward +inf). The first-sample result is y = (x + 1) >>> 1.
- Undefined: results use a plain arithmetic shift (floor), as specified above.
- Handshakes, latency and FSM are identical in both builds.

Test Plan:
- Reset then single channel: ch0 sends 100 then 50 with out_ready=1 -> outputs 50 (ch0) then 75 (ch0), each one cycle after acceptance.
- Round-robin: all 4 in_valid held high, out_ready=1 -> grant order 0,1,2,3,0. in_ready is one-hot every cycle.
- Backpressure: ch1 sends 20 and out_ready=0 for 3 cycles -> out_data=10 and out_ch=1 held, in_ready=0. Accepted on the first out_ready=1 cycle, with a new grant on that same cycle.
- Negative/extreme values: ch2 sends -262144 then -262144 -> results -131072, -262144, with no wrap. Under FILTER_ROUND_EN, -3 then -2 -> results -1, -2 (floor build gives -2, -3).
- Flush with pending output: ch0 history=40, out_valid=1, out_ready=0, flush pulse -> FSM goes to DRAIN. After the drain, FLUSH lasts 1 cycle with in_ready=0. The next ch0 sample 8 yields 4.
- Async reset mid-stream: rst_n low while out_valid=1 -> out_valid=0 immediately. After release, ch3's first sample 6 yields 3.

Source files
------------

// File: rtl/filter_ch_scheduler.sv
// filter_ch_scheduler: one 2-tap averager y = (x(n) + x(n-1)) / 2 shared by
// N_CH channels through a round-robin arbiter, with a channel-tagged output.
// Build option: define FILTER_ROUND_EN to round half toward +inf instead of
// flooring.
module filter_ch_scheduler #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned DW   = 19,
    parameter int unsigned CW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      in_valid,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic [N_CH-1:0]      in_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [CW-1:0]        out_ch,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

`ifdef FILTER_ROUND_EN
    localparam logic signed [DW:0] RND_BIAS = (DW+1)'(1);
`else
    localparam logic signed [DW:0] RND_BIAS = '0;
`endif

    state_e                 state_q;
    logic [CW-1:0]          ptr_q;
    logic                   out_valid_q;
    logic [DW-1:0]          out_data_q;
    logic [CW-1:0]          out_ch_q;
    logic signed [DW-1:0]   hist_q [N_CH];
    logic [N_CH-1:0]        first_q;

    logic                   slot_free_c;
    logic                   grant_en_c;
    logic                   gnt_vld_c;
    logic [CW-1:0]          gnt_ch_c;
    logic                   accept_c;
    logic [CW-1:0]          ptr_nxt_c;
    logic signed [DW-1:0]   x_c;
    logic signed [DW-1:0]   base_c;
    logic signed [DW:0]     sum_c;
    logic [DW-1:0]          y_c;
    int unsigned            arb_idx_c;

    // Output slot can take a new result if empty or being drained this cycle.
    assign slot_free_c = !out_valid_q || out_ready;
    // Grants only in RUN; a flush request pre-empts any grant.
    assign grant_en_c  = (state_q == ST_RUN) && !flush && slot_free_c;
    assign accept_c    = grant_en_c && gnt_vld_c;

    // Round-robin search from the pointer upward, modulo N_CH.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_ch_c  = '0;
        arb_idx_c = 0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            arb_idx_c = 32'(ptr_q) + i;
            if (arb_idx_c >= N_CH) begin
                arb_idx_c = arb_idx_c - N_CH;
            end
            if (!gnt_vld_c && in_valid[CW'(arb_idx_c)]) begin
                gnt_vld_c = 1'b1;
                gnt_ch_c  = CW'(arb_idx_c);
            end
        end
    end

    // One-hot accept toward the granted channel.
    always_comb begin
        in_ready = '0;
        if (accept_c) begin
            in_ready = (N_CH)'(1) << gnt_ch_c;
        end
    end

    // Pointer advances past the granted channel, wrapping at N_CH.
    assign ptr_nxt_c = (32'(gnt_ch_c) == N_CH - 1) ? '0 : CW'(32'(gnt_ch_c) + 1);

    // Averaging datapath; a first sample averages against zero.
    always_comb begin
        x_c    = in_data[gnt_ch_c*DW +: DW];
        base_c = first_q[gnt_ch_c] ? '0 : hist_q[gnt_ch_c];
        sum_c  = {x_c[DW-1], x_c} + {base_c[DW-1], base_c} + RND_BIAS;
        y_c    = DW'(sum_c >>> 1);
    end

    // Flush sequencing: wait for a pending result to leave, then clear once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (flush) begin
                        state_q <= slot_free_c ? ST_FLUSH : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    // Output slot and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            out_data_q  <= y_c;
            out_ch_q    <= gnt_ch_c;
            ptr_q       <= ptr_nxt_c;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Per-channel history and first-sample flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                hist_q[i] <= '0;
            end
            first_q <= '1;
        end else if (state_q == ST_FLUSH) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                hist_q[i] <= '0;
            end
            first_q <= '1;
        end else if (accept_c) begin
            hist_q[gnt_ch_c]  <= x_c;
            first_q[gnt_ch_c] <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q != ST_RUN) || out_valid_q;

endmodule
